// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit with start/stall/advance handshake
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  input  logic             cancel,
  input  logic             advance,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic fin, is_div, neg_q, neg_r, sgn, accept, step, nb;
  logic [WIDTH-1:0] r, q, m, abs_a, abs_b;
  logic [WIDTH:0] sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  assign sgn = ~op[0];
  assign abs_a = (sgn & a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn & b[WIDTH-1]) ? -b : b;
  assign accept = state == IDLE && start && !cancel && !hold;
  assign step = state == BUSY && !hold && !cancel;
  assign sum = {1'b0, r} + {1'b0, m & {WIDTH{q[0]}}};
  assign shifted = {r, q[WIDTH-1]};
  assign diff = shifted - {1'b0, m};
  assign nb = ~diff[WIDTH];
  assign prod = {r, q};
  assign stall = start & ~valid;
  assign busy = state == BUSY;
  assign valid = state == DONE;
  always_comb begin
    nxt = cancel ? IDLE :
          (state == IDLE && start && !hold) ? BUSY :
          (state == BUSY && fin && !hold) ? DONE :
          (state == DONE && advance && !hold) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      m <= '0;
      cnt <= '0;
      fin <= 1'b0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      r <= '0;
      q <= op[1] ? abs_a : abs_b;
      m <= op[1] ? abs_b : abs_a;
      cnt <= CNT_W'(WIDTH - 1);
      fin <= 1'b0;
      is_div <= op[1];
      neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn & a[WIDTH-1];
    end else if (step && fin) begin
      {hi, lo} <= is_div ? {neg_r ? -r : r, neg_q ? -q : q} : (neg_q ? -prod : prod);
    end else if (step) begin
      {r, q} <= is_div ? {nb ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], q[WIDTH-2:0], nb}
                       : {sum, q[WIDTH-1:1]};
      cnt <= cnt - CNT_W'(cnt != '0);
      fin <= cnt == '0;
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized and directed checks of muldiv_iter against an arithmetic reference model
module tb_muldiv_iter;
  logic clk = 1'b0;
  logic rst, start, hold, cancel, advance;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo;
  logic stall, busy, valid;
  logic start8;
  logic [1:0] op8;
  logic [7:0] a8, b8, hi8, lo8;
  logic stall8, busy8, valid8;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] last;
  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .hold(hold),
    .cancel(cancel), .advance(advance), .stall(stall), .busy(busy), .valid(valid),
    .hi(hi), .lo(lo)
  );
  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .hold(hold),
    .cancel(cancel), .advance(advance), .stall(stall8), .busy(busy8), .valid(valid8),
    .hi(hi8), .lo(lo8)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: return (y == 0) ? {x, (sx < 0) ? 32'h1 : 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
  endfunction
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold_at, input int hold_len);
    int cyc;
    logic [63:0] e;
    e = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; advance = 1'b0;
    #1 check("stall-start", stall, 1);
    @(posedge clk);
    #1 check("accept", busy, 1);
    op = 2'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    while (!valid && cyc < 200) begin
      @(negedge clk);
      hold = cyc >= hold_at && cyc < hold_at + hold_len;
      if (cyc == 5) check("stall-busy", stall, 1);
      @(posedge clk);
      #1 cyc++;
    end
    hold = 1'b0;
    check("latency", cyc, 33 + hold_len);
    check($sformatf("result op%0d %h %h", o, x, y), {hi, lo}, e);
    last = e;
    @(negedge clk);
    advance = 1'b1; start = 1'b0;
    @(posedge clk);
    #1 check("retire", valid, 0);
    @(negedge clk);
    advance = 1'b0;
  endtask
  initial begin
    int cyc;
    logic seen;
    logic [63:0] e;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; hold = 1'b0; cancel = 1'b0; advance = 1'b0;
    op = '0; a = '0; b = '0; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset-busy", busy, 0);
    check("reset-valid", valid, 0);
    check("reset-hilo", {hi, lo}, 0);
    check("reset-stall", stall, 0);
    do_op(2'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("mult-const", last, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("multu-const", last, 64'h0000_0001_FFFF_FFFE);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(2'd3, 32'd100, 32'd7, 0, 0);
    do_op(2'd3, 32'h1234, 32'd0, 0, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("divovf-const", last, 64'h0000_0000_8000_0000);
    do_op(2'd2, 32'h8765_4321, 32'h321, 10, 5);
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        default: ;
      endcase
      do_op(2'($urandom_range(0, 3)), x, y, $urandom_range(0, 25), $urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = $urandom; b = $urandom | 32'd1;
    @(posedge clk);
    #1 check("cancel-accept", busy, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1; start = 1'b0;
    @(posedge clk);
    #1 check("cancel-busy", busy, 0);
    check("cancel-valid", valid, 0);
    @(negedge clk);
    cancel = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= valid;
    end
    check("cancel-novalid", seen, 0);
    check("cancel-hilo", {hi, lo}, last);
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
    e = model(op, a, b);
    wait_valid(cyc);
    check("dh-latency", cyc, 34);
    check("dh-result", {hi, lo}, e);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("dh-valid", valid, 1);
      check("dh-norestart", busy, 0);
      check("dh-hilo", {hi, lo}, e);
    end
    @(negedge clk);
    advance = 1'b1; op = 2'd3; a = $urandom; b = $urandom_range(1, 1000);
    e = model(op, a, b);
    @(posedge clk);
    #1 check("adv-valid", valid, 0);
    check("adv-busy", busy, 0);
    check("adv-stall", stall, 1);
    @(negedge clk);
    advance = 1'b0;
    @(posedge clk);
    #1 check("adv-accept", busy, 1);
    check("adv-stall2", stall, 1);
    wait_valid(cyc);
    check("adv-latency", cyc, 33);
    check("adv-result", {hi, lo}, e);
    @(negedge clk);
    advance = 1'b1; start = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1 check("rst-busy", busy, 0);
    check("rst-valid", valid, 0);
    check("rst-hilo", {hi, lo}, 0);
    @(negedge clk);
    rst = 1'b0;
    start8 = 1'b1; op8 = 2'd0; a8 = 8'hFF; b8 = 8'd2;
    @(posedge clk);
    #1 check("w8-accept", busy8, 1);
    cyc = 0;
    while (!valid8 && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("w8-latency", cyc, 9);
    check("w8-result", {hi8, lo8}, 16'hFFFE);
    @(negedge clk);
    start8 = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
